// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_pkg
//  Purpose  : Shared AHB-lite encodings for the bus arbiter: HTRANS and
//             HBURST codes, arbiter state type, and the HBURST -> (beats-1)
//             helper used to load the burst beat counter.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  // Beats remaining after the NONSEQ beat of a burst. Wrapping and
  // incrementing bursts of the same length are equivalent here. SINGLE and
  // undefined-length INCR return 0: the arbiter may re-arbitrate after
  // every such beat.
  function automatic logic [3:0] burst_len_m1(input logic [2:0] hburst);
    logic [3:0] len_m1;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  len_m1 = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  len_m1 = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: len_m1 = 4'd15;
      HBURST_SINGLE, HBURST_INCR:   len_m1 = 4'd0;
      default:                      len_m1 = 4'd0;
    endcase
    return len_m1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_rr_picker
//  Purpose  : Combinational round-robin picker. Scans the request vector
//             starting at index i_ptr and wrapping. It returns the first
//             requester found.
//  Ports    : i_req    - per-manager request vector
//             i_ptr    - index to start the scan from (highest priority)
//             o_onehot - one-hot winner (all zero when nobody requests)
//             o_idx    - winner index (0 when nobody requests)
//             o_found  - at least one request was present
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_rr_picker #(
  parameter  int NUM_MGR = 4,
  localparam int MGR_W   = $clog2(NUM_MGR)
) (
  input  logic [NUM_MGR-1:0] i_req,
  input  logic [MGR_W-1:0]   i_ptr,
  output logic [NUM_MGR-1:0] o_onehot,
  output logic [MGR_W-1:0]   o_idx,
  output logic               o_found
);

  logic [MGR_W-1:0] w_cand;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    w_cand   = '0;
    for (int i = 0; i < NUM_MGR; i++) begin
      w_cand = MGR_W'((32'(i_ptr) + 32'(i)) % NUM_MGR);
      if (!o_found && i_req[w_cand]) begin
        o_found          = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_bus_arbiter
//  Purpose  : Shares one AHB-lite slave-side bus between NUM_MGR managers.
//             Round-robin grants change only at transfer/burst boundaries.
//             Address/control come from the address-phase owner, HWDATA
//             from the data-phase owner. HREADY is gated back to each
//             manager.
//  Ports    : i_hclk, i_hreset      - clock, async active-high reset
//             i_hbusreq             - per-manager bus request
//             i_haddr..i_hwdata     - packed per-manager AHB signals
//             i_hready              - HREADY from the slave mux
//             o_hgrant              - one-hot address-phase grant
//             o_hmaster/o_hmaster_d - address/data-phase owner index
//             o_haddr..o_hwdata     - muxed bus towards the slaves
//             o_mgr_hready          - per-manager gated HREADY
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter  int NUM_MGR    = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int MGR_W      = $clog2(NUM_MGR)
) (
  input  logic                          i_hclk,
  input  logic                          i_hreset,
  input  logic [NUM_MGR-1:0]            i_hbusreq,
  input  logic [NUM_MGR*ADDR_WIDTH-1:0] i_haddr,
  input  logic [NUM_MGR*2-1:0]          i_htrans,
  input  logic [NUM_MGR-1:0]            i_hwrite,
  input  logic [NUM_MGR*3-1:0]          i_hsize,
  input  logic [NUM_MGR*3-1:0]          i_hburst,
  input  logic [NUM_MGR*DATA_WIDTH-1:0] i_hwdata,
  input  logic                          i_hready,
  output logic [NUM_MGR-1:0]            o_hgrant,
  output logic [MGR_W-1:0]              o_hmaster,
  output logic [MGR_W-1:0]              o_hmaster_d,
  output logic [ADDR_WIDTH-1:0]         o_haddr,
  output logic [1:0]                    o_htrans,
  output logic                          o_hwrite,
  output logic [2:0]                    o_hsize,
  output logic [2:0]                    o_hburst,
  output logic [DATA_WIDTH-1:0]         o_hwdata,
  output logic [NUM_MGR-1:0]            o_mgr_hready
);

  localparam logic [MGR_W-1:0] c_last_idx = MGR_W'(NUM_MGR - 1);

  arb_state_t         r_state,     w_state_nxt;
  logic [NUM_MGR-1:0] r_hgrant,    w_hgrant_nxt;
  logic [MGR_W-1:0]   r_hmaster,   w_hmaster_nxt;
  logic [MGR_W-1:0]   r_rr_ptr,    w_rr_ptr_nxt;
  logic [3:0]         r_beat_cnt,  w_beat_cnt_nxt;
  logic [MGR_W-1:0]   r_hmaster_d;
  logic               r_d_valid;

  logic [ADDR_WIDTH-1:0] w_own_haddr;
  logic [1:0]            w_own_htrans;
  logic                  w_own_hwrite;
  logic [2:0]            w_own_hsize;
  logic [2:0]            w_own_hburst;
  logic [DATA_WIDTH-1:0] w_dat_hwdata;

  logic [NUM_MGR-1:0] w_pick_onehot;
  logic [MGR_W-1:0]   w_pick_idx;
  logic               w_pick_found;
  logic               w_boundary;

  // ---------------------------------------------------------------------------
  // Owner muxes: address/control follow r_hmaster, write data follows the
  // data-phase owner.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_own_haddr  = i_haddr[0 +: ADDR_WIDTH];
    w_own_htrans = i_htrans[0 +: 2];
    w_own_hwrite = i_hwrite[0];
    w_own_hsize  = i_hsize[0 +: 3];
    w_own_hburst = i_hburst[0 +: 3];
    w_dat_hwdata = i_hwdata[0 +: DATA_WIDTH];
    for (int k = 0; k < NUM_MGR; k++) begin
      if (MGR_W'(k) == r_hmaster) begin
        w_own_haddr  = i_haddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        w_own_htrans = i_htrans[k*2 +: 2];
        w_own_hwrite = i_hwrite[k];
        w_own_hsize  = i_hsize[k*3 +: 3];
        w_own_hburst = i_hburst[k*3 +: 3];
      end
      if (MGR_W'(k) == r_hmaster_d) begin
        w_dat_hwdata = i_hwdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign o_hgrant    = r_hgrant;
  assign o_hmaster   = r_hmaster;
  assign o_hmaster_d = r_hmaster_d;
  assign o_haddr     = w_own_haddr;
  // With nobody owning the bus, the last owner's HTRANS must not leak out.
  assign o_htrans    = (r_state == ARB_OWN) ? w_own_htrans : HTRANS_IDLE;
  assign o_hwrite    = w_own_hwrite;
  assign o_hsize     = w_own_hsize;
  assign o_hburst    = w_own_hburst;
  assign o_hwdata    = w_dat_hwdata;

  ahb_rr_picker #(
    .NUM_MGR (NUM_MGR)
  ) u_picker (
    .i_req    (i_hbusreq),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_found  (w_pick_found)
  );

  // ---------------------------------------------------------------------------
  // Boundary detection. r_beat_cnt holds the beats still to come after the
  // last accepted beat. The SEQ seen while it is 1 is therefore the final
  // beat of the burst. 0 also counts, so a stray SEQ cannot lock the bus.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_boundary = 1'b0;
    if (r_state == ARB_IDLE) begin
      w_boundary = 1'b1;
    end else begin
      case (w_own_htrans)
        HTRANS_IDLE:   w_boundary = 1'b1;
        HTRANS_NONSEQ: w_boundary = (burst_len_m1(w_own_hburst) == 4'd0);
        HTRANS_SEQ:    w_boundary = (r_beat_cnt <= 4'd1);
        default:       w_boundary = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Everything holds while the slave inserts wait states.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_hgrant_nxt   = r_hgrant;
    w_hmaster_nxt  = r_hmaster;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    if (i_hready) begin
      case (o_htrans)
        HTRANS_NONSEQ: w_beat_cnt_nxt = burst_len_m1(w_own_hburst);
        HTRANS_SEQ: begin
          if (r_beat_cnt != 4'd0) begin
            w_beat_cnt_nxt = r_beat_cnt - 4'd1;
          end
        end
        HTRANS_BUSY: w_beat_cnt_nxt = r_beat_cnt;
        default:     w_beat_cnt_nxt = r_beat_cnt;
      endcase
      if (w_boundary) begin
        if (w_pick_found) begin
          w_state_nxt   = ARB_OWN;
          w_hgrant_nxt  = w_pick_onehot;
          w_hmaster_nxt = w_pick_idx;
          w_rr_ptr_nxt  = (w_pick_idx == c_last_idx) ? '0 : (w_pick_idx + MGR_W'(1));
        end else begin
          // o_hmaster keeps its last value so the muxes stay quiet.
          w_state_nxt  = ARB_IDLE;
          w_hgrant_nxt = '0;
        end
      end
    end
  end

  always_ff @(posedge i_hclk or posedge i_hreset) begin
    if (i_hreset) begin
      r_state     <= ARB_IDLE;
      r_hgrant    <= '0;
      r_hmaster   <= '0;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
      r_hmaster_d <= '0;
      r_d_valid   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hgrant   <= w_hgrant_nxt;
      r_hmaster  <= w_hmaster_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      if (i_hready) begin
        r_hmaster_d <= r_hmaster;
        r_d_valid   <= (o_htrans == HTRANS_NONSEQ) || (o_htrans == HTRANS_SEQ);
      end
    end
  end

  // A manager sees HREADY only while it owns the address phase or the data
  // phase in flight. Everyone else is stalled.
  for (genvar k = 0; k < NUM_MGR; k++) begin : g_mgr_hready
    assign o_mgr_hready[k] = i_hready &
                             (r_hgrant[k] | (r_d_valid & (r_hmaster_d == MGR_W'(k))));
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_bus_arbiter
//  Purpose  : Self-checking bench for ahb_bus_arbiter (4 managers, 32/32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_bus_arbiter;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR4 = 3'd3, B_WRAP8 = 3'd4,
                         B_INCR8 = 3'd5, B_INCR16 = 3'd7;

  logic         hclk = 1'b0;
  logic         hreset;
  logic [3:0]   hbusreq;
  logic [127:0] haddr;
  logic [7:0]   htrans;
  logic [3:0]   hwrite;
  logic [11:0]  hsize;
  logic [11:0]  hburst;
  logic [127:0] hwdata;
  logic         hready;
  logic [3:0]   o_hgrant;
  logic [1:0]   o_hmaster;
  logic [1:0]   o_hmaster_d;
  logic [31:0]  o_haddr;
  logic [1:0]   o_htrans;
  logic         o_hwrite;
  logic [2:0]   o_hsize;
  logic [2:0]   o_hburst;
  logic [31:0]  o_hwdata;
  logic [3:0]   o_mgr_hready;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  ahb_bus_arbiter #(.NUM_MGR(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_hclk       (hclk),
    .i_hreset     (hreset),
    .i_hbusreq    (hbusreq),
    .i_haddr      (haddr),
    .i_htrans     (htrans),
    .i_hwrite     (hwrite),
    .i_hsize      (hsize),
    .i_hburst     (hburst),
    .i_hwdata     (hwdata),
    .i_hready     (hready),
    .o_hgrant     (o_hgrant),
    .o_hmaster    (o_hmaster),
    .o_hmaster_d  (o_hmaster_d),
    .o_haddr      (o_haddr),
    .o_htrans     (o_htrans),
    .o_hwrite     (o_hwrite),
    .o_hsize      (o_hsize),
    .o_hburst     (o_hburst),
    .o_hwdata     (o_hwdata),
    .o_mgr_hready (o_mgr_hready)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #2;
  endtask

  task automatic set_mgr(input int m, input logic [1:0] t, input logic [2:0] b, input logic [31:0] a);
    htrans[m*2 +: 2] = t;
    hburst[m*3 +: 3] = b;
    haddr[m*32 +: 32] = a;
  endtask

  task automatic do_reset();
    hreset  = 1'b1;
    hbusreq = '0; haddr = '0; htrans = '0; hwrite = '0;
    hsize   = {4{3'd2}}; hburst = '0; hwdata = '0; hready = 1'b1;
    step();
    step();
    chk("rst_grant",     64'(o_hgrant),     64'h0);
    chk("rst_hmaster",   64'(o_hmaster),    64'h0);
    chk("rst_hmaster_d", 64'(o_hmaster_d),  64'h0);
    chk("rst_htrans",    64'(o_htrans),     64'(T_IDLE));
    chk("rst_mgr_hrdy",  64'(o_mgr_hready), 64'h0);
    hreset = 1'b0;
  endtask

  // Drive a burst from manager m, optionally with a wait-state or BUSY gap
  // of gap_n cycles after beat gap_after, checking the grant never moves
  // until the final beat has been accepted.
  task automatic do_burst(input int m, input logic [2:0] b, input int beats,
                          input int gap_after, input int gap_n, input bit use_busy,
                          input logic [31:0] base, input logic [3:0] exp_next);
    logic [3:0] own;
    own = 4'b0001 << m;
    for (int i = 0; i < beats; i++) begin
      hready = 1'b1;
      set_mgr(m, (i == 0) ? T_NSEQ : T_SEQ, b, base + 32'(4 * i));
      #1;
      chk("burst_grant", 64'(o_hgrant), 64'(own));
      chk("burst_haddr", 64'(o_haddr),  64'(base + 32'(4 * i)));
      step();
      if (i == gap_after) begin
        for (int g = 0; g < gap_n; g++) begin
          if (use_busy) set_mgr(m, T_BUSY, b, base + 32'(4 * (i + 1)));
          else          hready = 1'b0;
          #1;
          chk("gap_grant",   64'(o_hgrant),  64'(own));
          chk("gap_hmaster", 64'(o_hmaster), 64'(m));
          if (!use_busy) chk("stall_mgr_hready", 64'(o_mgr_hready), 64'h0);
          step();
        end
      end
    end
    #1;
    chk("burst_next_grant", 64'(o_hgrant), 64'(exp_next));
    set_mgr(m, T_IDLE, B_SINGLE, 32'h0);
  endtask

  function automatic int blen(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  typedef struct {
    logic [3:0] req;
    logic [1:0] tr;
    logic       rdy;
    logic [3:0] exp_grant;
    logic [1:0] exp_htrans;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Round-robin ordering on SINGLE transfers, wait-state hold, bus release.
    tbl[0] = '{4'b1111, T_NSEQ, 1'b1, 4'b0001, T_NSEQ};
    tbl[1] = '{4'b1111, T_NSEQ, 1'b1, 4'b0010, T_NSEQ};
    tbl[2] = '{4'b1111, T_NSEQ, 1'b1, 4'b0100, T_NSEQ};
    tbl[3] = '{4'b1111, T_NSEQ, 1'b1, 4'b1000, T_NSEQ};
    tbl[4] = '{4'b1111, T_NSEQ, 1'b1, 4'b0001, T_NSEQ};
    tbl[5] = '{4'b1111, T_NSEQ, 1'b0, 4'b0001, T_NSEQ};
    tbl[6] = '{4'b0000, T_NSEQ, 1'b1, 4'b0000, T_IDLE};
    tbl[7] = '{4'b0100, T_NSEQ, 1'b1, 4'b0100, T_NSEQ};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      hbusreq = tbl[i].req;
      htrans  = {4{tbl[i].tr}};
      hburst  = '0;
      hready  = tbl[i].rdy;
      step();
      chk("tbl_grant",  64'(o_hgrant), 64'(tbl[i].exp_grant));
      chk("tbl_htrans", 64'(o_htrans), 64'(tbl[i].exp_htrans));
    end

    // INCR4 from mgr1; mgr1 drops its request, mgr2 waits for the 4th beat.
    do_reset();
    hbusreq = 4'b0010;
    step();
    chk("incr4_grant0", 64'(o_hgrant), 64'h2);
    hbusreq = 4'b0100;
    do_burst(1, B_INCR4, 4, -1, 0, 1'b0, 32'h100, 4'b0100);

    // Data phase follows the address-phase owner even after the grant moves.
    do_reset();
    hbusreq = 4'b1001;
    step();
    chk("wr_grant0", 64'(o_hgrant), 64'h1);
    set_mgr(0, T_NSEQ, B_SINGLE, 32'h40);
    hwrite[0] = 1'b1;
    hwdata[0 +: 32]  = 32'hA5A5A5A5;
    hwdata[96 +: 32] = 32'h3C3C3C3C;
    #1;
    chk("wr_haddr",  64'(o_haddr),  64'h40);
    chk("wr_hwrite", 64'(o_hwrite), 64'h1);
    step();
    set_mgr(0, T_IDLE, B_SINGLE, 32'h0);
    #1;
    chk("wr_grant1",    64'(o_hgrant),     64'h8);
    chk("wr_hmaster",   64'(o_hmaster),    64'h3);
    chk("wr_hmaster_d", 64'(o_hmaster_d),  64'h0);
    chk("wr_hwdata",    64'(o_hwdata),     64'hA5A5A5A5);
    chk("wr_mgr_hrdy",  64'(o_mgr_hready), 64'h9);

    // WRAP8 from mgr0 with 3 wait states after beat 3.
    do_reset();
    hbusreq = 4'b0001;
    step();
    hbusreq = 4'b0011;
    do_burst(0, B_WRAP8, 8, 2, 3, 1'b0, 32'h200, 4'b0010);

    // INCR8 from mgr2 with two BUSY cycles after beat 4.
    do_reset();
    hbusreq = 4'b0100;
    step();
    hbusreq = 4'b0101;
    do_burst(2, B_INCR8, 8, 3, 2, 1'b1, 32'h300, 4'b0001);

    // Asynchronous reset during beat 2 of INCR16.
    do_reset();
    hbusreq = 4'b0001;
    step();
    set_mgr(0, T_NSEQ, B_INCR16, 32'h400);
    step();
    set_mgr(0, T_SEQ, B_INCR16, 32'h404);
    hbusreq = 4'b1010;
    #1;
    chk("r16_grant_pre", 64'(o_hgrant), 64'h1);
    hreset = 1'b1;
    #1;
    chk("r16_grant_rst",  64'(o_hgrant), 64'h0);
    chk("r16_htrans_rst", 64'(o_htrans), 64'(T_IDLE));
    #1;
    hreset = 1'b0;
    set_mgr(0, T_IDLE, B_SINGLE, 32'h0);
    step();
    chk("r16_first_grant", 64'(o_hgrant), 64'h2);

    // Randomised traffic against a transfer-level reference model.
    begin
      int owner, rr, last_m, dm, done_b, total_b, t;
      bit dv, bnd;
      logic [3:0] eg, emh;
      logic [2:0] bo;
      do_reset();
      owner = -1; rr = 0; last_m = 0; dm = 0; dv = 1'b0; done_b = 0; total_b = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        hbusreq = 4'($urandom);
        hready  = ($urandom_range(0, 4) != 0);
        for (int m = 0; m < 4; m++) begin
          int r;
          logic [1:0] tr;
          r  = $urandom_range(0, 9);
          tr = (r < 2) ? T_IDLE : (r < 4) ? T_NSEQ : (r < 5) ? T_BUSY : T_SEQ;
          set_mgr(m, tr, 3'($urandom_range(0, 7)), $urandom);
          hwdata[m*32 +: 32] = $urandom;
          hwrite[m] = 1'($urandom);
        end
        #1;
        eg = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
        t  = (owner >= 0) ? int'(htrans[owner*2 +: 2]) : 0;
        bo = (owner >= 0) ? hburst[owner*3 +: 3] : 3'd0;
        for (int k = 0; k < 4; k++)
          emh[k] = hready && ((owner == k) || (dv && dm == k));
        chk("rnd_grant",    64'(o_hgrant),     64'(eg));
        chk("rnd_hmaster",  64'(o_hmaster),    64'(last_m));
        chk("rnd_htrans",   64'(o_htrans),     64'(t));
        chk("rnd_haddr",    64'(o_haddr),      64'(haddr[last_m*32 +: 32]));
        chk("rnd_hmaster_d",64'(o_hmaster_d),  64'(dm));
        chk("rnd_hwdata",   64'(o_hwdata),     64'(hwdata[dm*32 +: 32]));
        chk("rnd_mgr_hrdy", 64'(o_mgr_hready), 64'(emh));
        if (hready) begin
          bnd = (owner < 0) || (t == 0) || (t == 2 && blen(bo) == 1) ||
                (t == 3 && done_b + 1 >= total_b);
          if (t == 2) begin
            done_b = 1; total_b = blen(bo);
          end else if (t == 3) begin
            done_b++;
          end
          dm = last_m;
          dv = (t >= 2);
          if (bnd) begin
            owner = -1;
            for (int k = 0; k < 4; k++) begin
              int idx;
              idx = (rr + k) % 4;
              if (owner < 0 && hbusreq[idx]) owner = idx;
            end
            if (owner >= 0) begin
              last_m = owner;
              rr = (owner + 1) % 4;
            end
          end
        end
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
